spart: RTL and testbench
========================

# spart

Special-purpose asynchronous receiver/transmitter (SPART) that sits directly downstream of the bus driver. It decodes the driver's `iocs`/`iorw`/`ioaddr`/`databus` transactions and generates the baud-rate enable from a programmed 16-bit divisor. It serialises written bytes onto `txd` as 8N1 frames, deserialises frames from `rxd`, and reports buffer status on `tbr` and `rda`.

## Interface
- No parameters. Frame format is fixed at 8N1, LSB first, 16x oversampling.
- `clk` input 1: system clock (100 MHz nominal).
- `rst` input 1: reset, asynchronous, active-low (asserted at 0).
- `iocs` input 1: chip select. A transaction happens only when it is 1.
- `iorw` input 1: 1 = read (SPART drives `databus`), 0 = write (driver drives `databus`).
- `ioaddr` input 2: register select.
  - 00: TX buffer on write, RX buffer on read.
  - 01: status, read-only.
  - 10: divisor low byte.
  - 11: divisor high byte.
- `databus` inout 8: shared data bus.
- `rda` output 1: receive data available.
- `tbr` output 1: transmit buffer ready (empty).
- `txd` output 1: serial out, idle high.
- `rxd` input 1: serial in, asynchronous to `clk`.

## Operation
- **Reset values:**
  - `txd`=1, `tbr`=1, `rda`=0.
  - RX buffer = 0x00.
  - Divisor = 0x0516; low-byte holding register = 0x16.
  - Baud counter = divisor.
  - TX and RX FSMs in IDLE.
  - `databus` is hi-z.
- **Bus writes:** sampled at posedge `clk` when `iocs`=1 and `iorw`=0.
  - 10: load the low-byte holding register only.
  - 11: commit divisor = {data, holding}, and reload the baud counter in the same edge.
  - 00 with `tbr`=1: load the TX shift register and clear `tbr` at that edge.
  - 00 with `tbr`=0: ignored.
  - 01: ignored.
- **Bus reads:** `databus` is driven combinationally when `iocs`=1 and `iorw`=1; otherwise it is hi-z.
  - 00: RX buffer.
  - 01: {6'b0, `tbr`, `rda`}.
  - 10: divisor[7:0].
  - 11: divisor[15:8].
- **Clearing `rda`:** a read of 00 clears `rda` at the posedge where the read is sampled.
- **Baud generator:** 16-bit down-counter.
  - When the counter equals 0, assert `tick` for one cycle and reload with divisor−1. Otherwise decrement.
  - Tick period = divisor cycles. A divisor of 0 or 1 gives a tick every cycle.
- **TX FSM:** IDLE → START → DATA → STOP → IDLE. Each state holds for 16 ticks; a 4-bit tick counter and a 3-bit bit index are required.
  - IDLE: `txd`=1.
  - START: `txd`=0.
  - DATA: 8 bits, LSB first, shifting right.
  - STOP: `txd`=1.
  - `tbr` returns to 1 in the cycle where the 16th STOP tick ends, as the FSM enters IDLE.
  - Bit timing is measured in ticks from the first tick after the load.
- **RX input:** `rxd` passes through a 2-flop synchroniser before any logic uses it.
- **RX FSM:** IDLE → START → DATA → STOP.
  - IDLE: a synchronised 1→0 transition enters START and clears the tick counter.
  - START: at tick 8, if the line is 1, treat it as a glitch and return to IDLE. Otherwise go to DATA and restart the count.
  - DATA: sample each bit at its 8th tick, for 8 bits, LSB first.
  - STOP: at the 8th tick, if the line is 1, load the RX buffer and set `rda`=1. If it is 0 (framing error), discard the byte and leave `rda` unchanged. In both cases return to IDLE.
- **Overrun:** a new valid byte while `rda`=1 overwrites the RX buffer, and `rda` stays 1.
- **Simultaneous RX completion and read of 00:** `rda` ends at 1. The read returns the old byte; the new byte is in the buffer afterwards.
- **Divisor commit mid-frame:** takes effect immediately on the counter. Frame integrity is not guaranteed.
- **Reset mid-frame:** both FSMs abort to IDLE, `txd`=1, `tbr`=1 immediately (asynchronously).

## Timing
- Write-to-register latency: 1 edge. `tbr` falls at the write edge.
- `txd` drops to 0 at the edge of the first tick after the load. Maximum delay is one divisor period plus 1 cycle.
- Frame length: 160 ticks = 160 × divisor cycles. For divisor 0x0516 that is 208,320 cycles.
- RX: `rda` rises 2 synchroniser cycles plus (8 + 16·9) ticks after the start edge on `rxd`, within ±1 tick.
- Reads are combinational, with no wait states. The driver must not drive `databus` while `iorw`=1.

## Test plan
- **Reset:** assert `rst`=0 → `txd`=1, `tbr`=1, `rda`=0, `databus`=z; read 10/11 → 0x16/0x05.
- **Divisor programming:** write 10←0x04, then 11←0x00 → read 11/10 returns 0x00/0x04; `tick` pulses every 4 cycles.
- **Transmit:** with divisor 4, write 00←0x41 → `tbr`=0 next cycle; `txd` carries 0, then 1,0,0,0,0,0,1,0, then 1, each bit 64 cycles; `tbr`=1 after 640 ± 4 cycles.
- **Write while busy:** write 00←0x55 while `tbr`=0 → ignored, and the frame still carries 0x41.
- **Loopback:** tie `txd` to `rxd` and send 0xA3 → `rda`=1; read 00 → 0xA3; `rda`=0 the next cycle. A status read of 01 before the clear returns 0x03 once `tbr`=1.
- **Error and glitch cases:**
  - Frame with stop bit 0 → `rda` stays 0.
  - 3-cycle low glitch on `rxd` → RX returns to IDLE with no byte.
  - Two frames without a read → `rda`=1 and the buffer holds the second byte.

Source files
------------

// File: rtl/spart.sv
`timescale 1ns/1ps
// SPART: bus-mapped 8N1 serial port with a programmable 16-bit baud divisor.
// TX serialises buffered bytes; RX deserialises frames with 16x oversampling.
module spart (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  localparam logic [15:0] DivReset = 16'h0516;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Bus decode
  logic       wr_en, rd_en, rd_rx, tx_load, div_commit;
  logic [7:0] rd_data;

  // Baud generator
  logic [7:0]  div_lo_q, div_lo_d;
  logic [15:0] divisor_q, divisor_d;
  logic [15:0] baud_q, baud_d;
  logic        tick;

  // Transmitter
  tx_state_e   tx_state_q, tx_state_d;
  logic [3:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tbr_q, tbr_d;

  // Receiver
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_fall;
  rx_state_e   rx_state_q, rx_state_d;
  logic [3:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_buf_q, rx_buf_d;
  logic        rda_q, rda_d;
  logic        rx_done;

  assign wr_en      = iocs & ~iorw;
  assign rd_en      = iocs & iorw;
  assign rd_rx      = rd_en & (ioaddr == 2'b00);
  assign tx_load    = wr_en & (ioaddr == 2'b00) & tbr_q;
  assign div_commit = wr_en & (ioaddr == 2'b11);

  ////////////////
  // Bus reads  //
  ////////////////

  always_comb begin
    rd_data = 8'h00;
    unique case (ioaddr)
      2'b00: rd_data = rx_buf_q;
      2'b01: rd_data = {6'b000000, tbr_q, rda_q};
      2'b10: rd_data = divisor_q[7:0];
      2'b11: rd_data = divisor_q[15:8];
    endcase
  end

  assign databus = rd_en ? rd_data : 8'hzz;

  ////////////////////
  // Baud generator //
  ////////////////////

  assign tick = (baud_q == 16'd0);

  always_comb begin
    div_lo_d  = div_lo_q;
    divisor_d = divisor_q;
    if (wr_en && (ioaddr == 2'b10)) div_lo_d = databus;
    if (div_commit) divisor_d = {databus, div_lo_q};
  end

  // A commit reloads the counter with the full divisor, so the first tick after a
  // commit is one cycle later than the steady-state period.
  always_comb begin
    if (div_commit) begin
      baud_d = {databus, div_lo_q};
    end else if (tick) begin
      baud_d = (divisor_q == 16'd0) ? 16'd0 : divisor_q - 16'd1;
    end else begin
      baud_d = baud_q - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_lo_q  <= DivReset[7:0];
      divisor_q <= DivReset;
      baud_q    <= DivReset;
    end else begin
      div_lo_q  <= div_lo_d;
      divisor_q <= divisor_d;
      baud_q    <= baud_d;
    end
  end

  /////////////////
  // Transmitter //
  /////////////////

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= 4'd0;
      tx_idx_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tbr_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tbr_q      <= tbr_d;
    end
  end

  // tbr low while in TxIdle means a byte is waiting for the next tick to start.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tbr_d      = tbr_q;
    unique case (tx_state_q)
      TxIdle: begin
        if (tx_load) begin
          tx_shift_d = databus;
          tbr_d      = 1'b0;
        end else if (!tbr_q && tick) begin
          tx_state_d = TxStart;
          tx_cnt_d   = 4'd0;
        end
      end
      TxStart: begin
        if (tick) begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) begin
            tx_state_d = TxData;
            tx_idx_d   = 3'd0;
          end
        end
      end
      TxData: begin
        if (tick) begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_idx_d   = tx_idx_q + 3'd1;
            if (tx_idx_q == 3'd7) tx_state_d = TxStop;
          end
        end
      end
      TxStop: begin
        if (tick) begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) begin
            tx_state_d = TxIdle;
            tbr_d      = 1'b1;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    unique case (tx_state_q)
      TxStart: txd = 1'b0;
      TxData:  txd = tx_shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  assign tbr = tbr_q;

  //////////////
  // Receiver //
  //////////////

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= 4'd0;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_buf_q   <= 8'h00;
      rda_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_buf_q   <= rx_buf_d;
      rda_q      <= rda_d;
    end
  end

  // After re-centring on mid-start, every later sample lands 16 ticks apart.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_fall) begin
          rx_state_d = RxStart;
          rx_cnt_d   = 4'd0;
        end
      end
      RxStart: begin
        if (tick) begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd7) begin
            rx_cnt_d   = 4'd0;
            rx_idx_d   = 3'd0;
            rx_state_d = rx_s2_q ? RxIdle : RxData;
          end
        end
      end
      RxData: begin
        if (tick) begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd15) begin
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            rx_idx_d   = rx_idx_q + 3'd1;
            if (rx_idx_q == 3'd7) rx_state_d = RxStop;
          end
        end
      end
      RxStop: begin
        if (tick && (rx_cnt_q == 4'd15)) begin
          rx_state_d = RxIdle;
        end else if (tick) begin
          rx_cnt_d = rx_cnt_q + 4'd1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    rx_done = (rx_state_q == RxStop) && tick && (rx_cnt_q == 4'd15) && rx_s2_q;
  end

  // A completing frame wins over a same-cycle read clear.
  always_comb begin
    rx_buf_d = rx_done ? rx_shift_q : rx_buf_q;
    rda_d    = rda_q;
    if (rd_rx)   rda_d = 1'b0;
    if (rx_done) rda_d = 1'b1;
  end

  assign rda = rda_q;

endmodule

// File: tb/tb_spart.sv
`timescale 1ns/1ps
// Self-checking bench for spart: bus access, baud tick, TX framing, RX with
// randomized frames checked against a byte-level model of buffer and rda.
module tb_spart;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       iocs     = 1'b0;
  logic       iorw     = 1'b0;
  logic [1:0] ioaddr   = 2'b00;
  logic [7:0] drv_data = 8'h00;
  logic       drv_en   = 1'b0;
  logic       rxd_drv  = 1'b1;
  logic       loop_en  = 1'b0;
  wire  [7:0] databus;
  wire        rxd_w;
  logic       rda, tbr, txd;

  assign databus = drv_en ? drv_data : 8'hzz;
  assign rxd_w   = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  spart dut (
    .clk     (clk),
    .rst     (rst),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rda     (rda),
    .tbr     (tbr),
    .txd     (txd),
    .rxd     (rxd_w)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Byte-level model of the receive side.
  logic [7:0] model_buf = 8'h00;
  logic       model_rda = 1'b0;

  localparam int BitCycles = 64;  // divisor 4 x 16 ticks

  bit   txw [700];
  bit   tbw [700];
  int   first_low, rise, first_tick, second_tick;
  logic [7:0] rdv, cap, rb;
  logic       good;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_data = d; drv_en = 1'b1;
    @(negedge clk);
    iocs = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  // Bit-bang one 8N1 frame on rxd and update the model.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic v;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) v = 1'b0;
      else if (k == 9) v = stop_bit;
      else v = b[k-1];
      @(negedge clk);
      rxd_drv = v;
      repeat (BitCycles - 1) @(negedge clk);
    end
    @(negedge clk);
    rxd_drv = 1'b1;
    if (stop_bit) begin
      model_buf = b;
      model_rda = 1'b1;
    end
  endtask

  task automatic glitch(input int len);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (len) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (80) @(negedge clk);
  endtask

  task automatic read_rx_and_check(input string tag);
    bus_read(2'b00, rdv);
    check_eq(tag, rdv, model_buf);
    model_rda = 1'b0;
    check_eq("rda_after_read", rda, model_rda);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("reset_txd", txd, 1'b1);
    check_eq("reset_tbr", tbr, 1'b1);
    check_eq("reset_rda", rda, 1'b0);
    rst = 1'b1;
    bus_read(2'b10, rdv); check_eq("reset_div_lo", rdv, 8'h16);
    bus_read(2'b11, rdv); check_eq("reset_div_hi", rdv, 8'h05);
    bus_read(2'b01, rdv); check_eq("reset_status", rdv, 8'h02);
    bus_read(2'b00, rdv); check_eq("reset_rxbuf", rdv, 8'h00);

    // Divisor programming
    bus_write(2'b10, 8'h04);
    bus_read(2'b11, rdv); check_eq("div_hi_before_commit", rdv, 8'h05);
    bus_write(2'b11, 8'h00);
    bus_read(2'b11, rdv); check_eq("div_hi", rdv, 8'h00);
    bus_read(2'b10, rdv); check_eq("div_lo", rdv, 8'h04);
    first_tick = -1; second_tick = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dut.tick) begin
        if (first_tick < 0) first_tick = i;
        else if (second_tick < 0) second_tick = i;
      end
    end
    check_eq("tick_period", second_tick - first_tick, 4);

    // Transmit 0x41, with an ignored write while busy
    bus_write(2'b00, 8'h41);
    check_eq("tbr_after_write", tbr, 1'b0);
    bus_write(2'b00, 8'h55);
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      txw[i] = txd;
      tbw[i] = tbr;
    end
    first_low = -1; rise = -1;
    for (int i = 0; i < 700; i++) begin
      if (first_low < 0 && !txw[i]) first_low = i;
      if (rise < 0 && tbw[i]) rise = i;
    end
    check_eq("tx_start_seen", first_low >= 0, 1'b1);
    if (first_low < 0) first_low = 0;
    for (int k = 1; k <= 8; k++) cap[k-1] = txw[first_low + BitCycles/2 + BitCycles*k];
    check_eq("tx_start_bit", txw[first_low + BitCycles/2], 1'b0);
    check_eq("tx_byte", cap, 8'h41);
    check_eq("tx_stop_bit", txw[first_low + BitCycles/2 + BitCycles*9], 1'b1);
    // capture index 0 is three cycles after the write edge
    check_eq("tbr_return_window", (rise + 3 >= 636) && (rise + 3 <= 644), 1'b1);

    // Loopback 0xA3
    loop_en = 1'b1;
    bus_write(2'b00, 8'hA3);
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (tbr) break;
    end
    check_eq("loop_tbr", tbr, 1'b1);
    check_eq("loop_rda", rda, 1'b1);
    bus_read(2'b01, rdv); check_eq("loop_status", rdv, 8'h03);
    model_buf = 8'hA3; model_rda = 1'b1;
    read_rx_and_check("loop_rxbuf");
    loop_en = 1'b0;
    repeat (10) @(negedge clk);

    // Framing error, glitch, overrun
    send_frame(8'h3C, 1'b0);
    repeat (30) @(negedge clk);
    check_eq("framing_err_rda", rda, model_rda);
    glitch(3);
    check_eq("glitch_rda", rda, model_rda);
    send_frame(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    send_frame(8'hC3, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("overrun_rda", rda, 1'b1);
    read_rx_and_check("overrun_rxbuf");

    // Randomized frames against the model
    for (int n = 0; n < 8; n++) begin
      rb   = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) glitch(int'($urandom_range(1, 4)));
      send_frame(rb, good);
      repeat (20 + $urandom_range(0, 30)) @(negedge clk);
      check_eq("rand_rda", rda, model_rda);
      bus_read(2'b01, rdv);
      check_eq("rand_status", rdv, {6'b000000, 1'b1, model_rda});
      if ($urandom_range(0, 1) == 1) read_rx_and_check("rand_rxbuf");
    end

    // Asynchronous reset mid-frame
    bus_write(2'b00, 8'h00);
    repeat (200) @(negedge clk);
    check_eq("midframe_tbr_busy", tbr, 1'b0);
    check_eq("midframe_txd_low", txd, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_eq("async_reset_tbr", tbr, 1'b1);
    check_eq("async_reset_txd", txd, 1'b1);
    check_eq("async_reset_rda", rda, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus_read(2'b11, rdv); check_eq("post_reset_div_hi", rdv, 8'h05);
    bus_read(2'b10, rdv); check_eq("post_reset_div_lo", rdv, 8'h16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
